// File: rtl/cpu_defs.sv
// Shared CPU definitions: CP0 register indices, exception codes, handler address
// and CP0 bit-field positions.
package cpu_defs;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam int unsigned SR_IM_LO     = 10;
    localparam int unsigned SR_IM_HI     = 15;
    localparam int unsigned SR_EXL       = 1;
    localparam int unsigned SR_IE        = 0;
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 and exception controller at the M stage: SR/Cause/EPC/PRId,
// interrupt/exception arbitration, pipeline-wide flush request, mfc0/mtc0/eret.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC,
    parameter logic [31:0] PRID_VAL   = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wd,
    output logic [31:0] cp0_rd,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [4:0]  m_exc_code,
    input  logic        m_eret,
    input  logic [5:0]  hw_int,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);
    import cpu_defs::*;

    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,       epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (m_exc_code != 5'd0) & ~sr_exl_q;
    assign req     = int_req | exc_req;

    assign sr_val    = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
    assign cause_val = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};

    assign epc_out    = epc_q;
    assign handler_pc = HANDLER_PC;

    // Reads return pre-edge state; a same-cycle mtc0 is not bypassed.
    always_comb begin
        cp0_rd = 32'b0;
        case (cp0_addr)
            CP0_SR:    cp0_rd = sr_val;
            CP0_CAUSE: cp0_rd = cause_val;
            CP0_EPC:   cp0_rd = epc_q;
            CP0_PRID:  cp0_rd = PRID_VAL;
            default:   cp0_rd = 32'b0;
        endcase
    end

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hw_int;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;

        if (req) begin
            // The M instruction is being flushed, so its mtc0/eret are dropped.
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? EXC_INT : m_exc_code;
            cause_bd_d  = m_bd;
            epc_d       = m_bd ? (m_pc - 32'd4) : m_pc;
        end else begin
            if (cp0_we) begin
                case (cp0_addr)
                    CP0_SR: begin
                        sr_im_d  = cp0_wd[SR_IM_HI:SR_IM_LO];
                        sr_exl_d = cp0_wd[SR_EXL];
                        sr_ie_d  = cp0_wd[SR_IE];
                    end
                    CP0_EPC: epc_d = {cp0_wd[31:2], 2'b00};
                    default: ;
                endcase
            end
            // eret after mtc0 so a same-cycle SR write still ends with EXL cleared.
            if (m_eret) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_im_q     <= 6'b0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'b0;
            cause_exc_q <= 5'b0;
            epc_q       <= 32'b0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

endmodule
